counter_slot_scheduler: RTL and testbench
=========================================

// Module: counter_slot_scheduler
// PURPOSE
//  Round-robin scheduler that shares one timed slot counter between NREQ requesters.
//  Each winner holds an exclusive grant for up to SLOT_LEN enabled cycles, tracked by an internal up-counter.
//  The grant ends early if the requester drops req.
//  Sits in front of the 4-bit counter datapath and sequences which client owns it.
// PARAMETERS
//  NREQ      4   number of requesters (2..8)
//  IDW       2   width of grant_id; 2**IDW >= NREQ
//  CNT_W     4   slot counter width; SLOT_LEN <= 2**CNT_W
//  SLOT_LEN  10  maximum enabled cycles per grant (>=1)
// PORTS
//  clk          in   1      clock; all state changes on posedge
//  reset        in   1      asynchronous, active-low reset
//  enable       in   1      global advance; low = freeze all state (pause)
//  req          in   NREQ   request vector, level-sensitive
//  grant        out  NREQ   one-hot grant, registered
//  grant_valid  out  1      high while any grant is active
//  grant_id     out  IDW    binary index of current or last grantee
//  slot_count   out  CNT_W  enabled cycles elapsed in current slot (0-based)
//  slot_done    out  1      1-cycle pulse: slot ended by expiry
//  grant_total  out  16     grants issued (only with SCHED_STATS_EN)
// BEHAVIOUR
//  Reset (reset=0, async):
//   - state=IDLE; grant=0, grant_valid=0, grant_id=0, slot_count=0, slot_done=0.
//   - RR pointer last_id=NREQ-1, so req[0] wins first.
//   - Applies immediately, including mid-slot.
//  FSM states: IDLE, GRANT, RELEASE.
//  IDLE:
//   - enable && |req: winner = first set req scanning last_id+1, +2, ... (mod NREQ).
//   - At that edge: grant=onehot(winner), grant_id=winner, slot_count=0, state=GRANT.
//   - Latency is 1 edge from the sampled req.
//   - !enable || req==0: stay IDLE, outputs hold.
//  GRANT, enable=1:
//   - slot_count==SLOT_LEN-1 (expiry): state=RELEASE, slot_done=1 next cycle.
//   - else !req[grant_id] (drop): state=RELEASE, slot_done=0.
//   - else slot_count+=1.
//   - Expiry and drop on the same cycle count as expiry.
//  GRANT, enable=0: everything holds; req drop is ignored until enable returns.
//  RELEASE (1 cycle):
//   - grant=0, grant_valid=0; slot_done high only if expiry caused the release.
//   - grant_id keeps the last winner; last_id=grant_id.
//   - Unconditional move to IDLE at next edge, enable ignored.
//  Slot timing: max 10 grant cycles + RELEASE + IDLE = back-to-back grants 12 cycles apart.
//  Output rules:
//   - grant is always one-hot or zero; grant_valid = |grant.
//   - slot_count never exceeds SLOT_LEN-1 and is not reset in RELEASE/IDLE (holds last value).
//   - Clears to 0 on the next grant.
//  Requests outside IDLE are not sampled; no queuing.
// CONFIGURATION
//  SCHED_STATS_EN defined:
//   - grant_total is a 16-bit counter, incremented on each IDLE->GRANT edge.
//   - Wraps 0xFFFF->0; reset to 0.
//  SCHED_STATS_EN undefined:
//   - grant_total is tied to 16'h0000; no counter logic.
// TESTING (NREQ=4, SLOT_LEN=10, CNT_W=4)
//  1. reset=0 for 2 cycles, then 1, with req=0, enable=1
//     -> all outputs 0, FSM stays IDLE for 20 cycles.
//  2. req=4'b0001 held, enable=1
//     -> grant=0001 after 1 edge; slot_count 0..9 over 10 cycles.
//     -> then grant=0 with slot_done=1 for 1 cycle; regrant 2 cycles later.
//  3. req=4'b1111 held
//     -> grant_id sequence 0,1,2,3,0; each slot 10 cycles; slot_done pulses 4 times.
//  4. enable=0 for 3 cycles when slot_count=5
//     -> slot_count stays 5, grant unchanged; resumes at 6; slot ends 3 cycles later.
//  5. req=4'b1100 with grant_id=2, req[2] dropped at slot_count=3
//     -> RELEASE with slot_done=0, next grant_id=3.
//  6. reset=0 asynchronously at slot_count=7
//     -> grant, slot_count, grant_valid read 0 before the next clock.
//     -> after release with req=1111, first grant_id=0.
//     -> with SCHED_STATS_EN, grant_total reads 0 after reset and counts each grant.

Source files
------------

// File: rtl/counter_slot_scheduler.sv
`default_nettype none
// =============================================================================
// Module   : counter_slot_scheduler
// Brief    : Round-robin scheduler granting one shared slot counter to NREQ
//            clients for up to SLOT_LEN enabled cycles. Optional grant
//            statistics counter enabled by defining SCHED_STATS_EN.
// Revision : 1.0 - initial release
// =============================================================================
module counter_slot_scheduler #(
   parameter int NREQ     = 4,
   parameter int IDW      = 2,
   parameter int CNT_W    = 4,
   parameter int SLOT_LEN = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic [NREQ-1:0]  req,
   output logic [NREQ-1:0]  grant,
   output logic             grant_valid,
   output logic [IDW-1:0]   grant_id,
   output logic [CNT_W-1:0] slot_count,
   output logic             slot_done,
   output logic [15:0]      grant_total
);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_GRANT   = 2'd1;
   localparam logic [1:0] ST_RELEASE = 2'd2;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SLOT_LEN - 1);
   localparam logic [IDW-1:0]   ID_LAST  = IDW'(NREQ - 1);
   localparam logic [NREQ-1:0]  ONE_HOT0 = NREQ'(1);

   logic [1:0]     state;
   logic [IDW-1:0] last_id;
   logic [IDW-1:0] scan_id;
   logic [IDW-1:0] win_id;
   logic           win_found;
   logic           start_grant;

   // Scan last_id+1, +2, ... with explicit wrap so non-power-of-two NREQ works.
   always_comb begin
      win_found = 1'b0;
      win_id    = '0;
      scan_id   = last_id;
      for (int k = 0; k < NREQ; k++) begin
         if (scan_id == ID_LAST) begin
            scan_id = '0;
         end else begin
            scan_id = scan_id + 1'b1;
         end
         if (!win_found && req[scan_id]) begin
            win_found = 1'b1;
            win_id    = scan_id;
         end
      end
   end

   assign start_grant = (state == ST_IDLE) && enable && win_found;
   assign grant_valid = |grant;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= ST_IDLE;
         grant      <= '0;
         grant_id   <= '0;
         slot_count <= '0;
         slot_done  <= 1'b0;
         last_id    <= ID_LAST;
      end else begin
         case (state)
            ST_IDLE: begin
               slot_done <= 1'b0;
               if (start_grant) begin
                  grant      <= ONE_HOT0 << win_id;
                  grant_id   <= win_id;
                  slot_count <= '0;
                  state      <= ST_GRANT;
               end
            end
            ST_GRANT: begin
               if (enable) begin
                  // Expiry takes precedence over a simultaneous request drop.
                  if (slot_count == CNT_LAST) begin
                     grant     <= '0;
                     slot_done <= 1'b1;
                     last_id   <= grant_id;
                     state     <= ST_RELEASE;
                  end else if (!req[grant_id]) begin
                     grant     <= '0;
                     slot_done <= 1'b0;
                     last_id   <= grant_id;
                     state     <= ST_RELEASE;
                  end else begin
                     slot_count <= slot_count + 1'b1;
                  end
               end
            end
            ST_RELEASE: begin
               slot_done <= 1'b0;
               state     <= ST_IDLE;
            end
            default: begin
               grant     <= '0;
               slot_done <= 1'b0;
               state     <= ST_IDLE;
            end
         endcase
      end
   end

`ifdef SCHED_STATS_EN
   logic [15:0] total_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         total_q <= '0;
      end else if (start_grant) begin
         total_q <= total_q + 16'd1;
      end
   end

   assign grant_total = total_q;
`else
   assign grant_total = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_counter_slot_scheduler.sv
`default_nettype none
// =============================================================================
// Module   : tb_counter_slot_scheduler
// Brief    : Vector table, directed corner sequences and randomized traffic
//            checked against an abstract slot-ownership model.
// Revision : 1.0 - initial release
// =============================================================================
module tb_counter_slot_scheduler;

   localparam int NREQ     = 4;
   localparam int SLOT_LEN = 10;

   logic        clk;
   logic        reset;
   logic        enable;
   logic [3:0]  req;
   logic [3:0]  grant;
   logic        grant_valid;
   logic [1:0]  grant_id;
   logic [3:0]  slot_count;
   logic        slot_done;
   logic [15:0] grant_total;

   int checks = 0;
   int errors = 0;

   // Abstract model: who owns the slot, how long, and whether a release cycle is pending.
   int m_owner;
   int m_id;
   int m_cnt;
   int m_last;
   int m_total;
   bit m_done;
   bit m_rel;

   counter_slot_scheduler #(
      .NREQ(4), .IDW(2), .CNT_W(4), .SLOT_LEN(10)
   ) dut (
      .clk(clk), .reset(reset), .enable(enable), .req(req),
      .grant(grant), .grant_valid(grant_valid), .grant_id(grant_id),
      .slot_count(slot_count), .slot_done(slot_done), .grant_total(grant_total)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       en;
      logic [3:0] rq;
      logic [3:0] gnt;
      logic [1:0] id;
      logic [3:0] cnt;
      logic       done;
   } vec_t;

   vec_t tbl [11];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_owner = -1; m_id = 0; m_cnt = 0; m_last = NREQ - 1;
      m_total = 0; m_done = 1'b0; m_rel = 1'b0;
   endtask

   task automatic model_step(input logic en, input logic [3:0] rq);
      int idx;
      if (m_rel) begin
         m_rel  = 1'b0;
         m_done = 1'b0;
      end else if (m_owner < 0) begin
         if (en && rq != 4'b0000) begin
            for (int k = 1; k <= NREQ; k++) begin
               idx = (m_last + k) % NREQ;
               if (m_owner < 0 && rq[idx[1:0]]) m_owner = idx;
            end
            m_id  = m_owner;
            m_cnt = 0;
            m_total++;
         end
      end else if (en) begin
         if (m_cnt == SLOT_LEN - 1 || !rq[m_owner[1:0]]) begin
            m_done  = (m_cnt == SLOT_LEN - 1);
            m_last  = m_owner;
            m_owner = -1;
            m_rel   = 1'b1;
         end else begin
            m_cnt++;
         end
      end
   endtask

   task automatic model_compare();
      logic [3:0]  eg;
      logic [15:0] et;
      eg = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
`ifdef SCHED_STATS_EN
      et = 16'(m_total);
`else
      et = 16'h0000;
`endif
      check("model", {4'h0, grant, grant_valid, grant_id, slot_count, slot_done, grant_total},
            {4'h0, eg, (m_owner >= 0), 2'(m_id), 4'(m_cnt), m_done, et});
   endtask

   // Inputs change 1 time unit after the edge; outputs are checked at the same point.
   task automatic drive(input logic en, input logic [3:0] rq);
      enable = en;
      req    = rq;
      @(posedge clk);
      #1;
      model_step(en, rq);
      model_compare();
   endtask

   task automatic do_reset();
      reset  = 1'b0;
      enable = 1'b1;
      req    = 4'b0000;
      repeat (2) @(posedge clk);
      #1;
      model_reset();
      check("reset_outputs", {grant, grant_valid, grant_id, slot_count, slot_done}, 12'h000);
      model_compare();
      reset = 1'b1;
   endtask

   initial begin
      int ids [5];
      int nid;
      int pulses;
      logic [3:0] prev_g;
      logic [3:0] rq;
      logic       en;
      bit         idle_ok;

      tbl[0]  = '{1'b1, 4'b0000, 4'b0000, 2'd0, 4'd0, 1'b0};
      tbl[1]  = '{1'b1, 4'b0100, 4'b0100, 2'd2, 4'd0, 1'b0};
      tbl[2]  = '{1'b1, 4'b0100, 4'b0100, 2'd2, 4'd1, 1'b0};
      tbl[3]  = '{1'b0, 4'b0000, 4'b0100, 2'd2, 4'd1, 1'b0};
      tbl[4]  = '{1'b1, 4'b0000, 4'b0000, 2'd2, 4'd1, 1'b0};
      tbl[5]  = '{1'b1, 4'b1111, 4'b0000, 2'd2, 4'd1, 1'b0};
      tbl[6]  = '{1'b1, 4'b1011, 4'b1000, 2'd3, 4'd0, 1'b0};
      tbl[7]  = '{1'b1, 4'b1000, 4'b1000, 2'd3, 4'd1, 1'b0};
      tbl[8]  = '{1'b1, 4'b0001, 4'b0000, 2'd3, 4'd1, 1'b0};
      tbl[9]  = '{1'b0, 4'b0011, 4'b0000, 2'd3, 4'd1, 1'b0};
      tbl[10] = '{1'b1, 4'b0011, 4'b0001, 2'd0, 4'd0, 1'b0};

      reset = 1'b1; enable = 1'b0; req = 4'b0000;
      model_reset();
      #2;

      // Reset then 20 idle cycles with no requests
      do_reset();
      idle_ok = 1'b1;
      for (int i = 0; i < 20; i++) begin
         drive(1'b1, 4'b0000);
         if (grant_valid !== 1'b0 || slot_done !== 1'b0) idle_ok = 1'b0;
      end
      check("idle_20", {31'd0, idle_ok}, 32'd1);

      // Vector table
      do_reset();
      for (int i = 0; i < 11; i++) begin
         drive(tbl[i].en, tbl[i].rq);
         check($sformatf("vec%0d", i), {grant, grant_id, slot_count, slot_done},
               {tbl[i].gnt, tbl[i].id, tbl[i].cnt, tbl[i].done});
      end

      // Single requester: full slot, expiry pulse, regrant two cycles later
      do_reset();
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, 4'b0001);
         check($sformatf("solo_cnt%0d", i), {grant, slot_count}, {4'b0001, 4'(i)});
      end
      drive(1'b1, 4'b0001);
      check("solo_release", {grant, slot_done, slot_count}, {4'b0000, 1'b1, 4'd9});
      drive(1'b1, 4'b0001);
      check("solo_idle", {grant, slot_done}, {4'b0000, 1'b0});
      drive(1'b1, 4'b0001);
      check("solo_regrant", {grant, slot_count}, {4'b0001, 4'd0});

      // All requesting: rotation 0,1,2,3,0 with four expiry pulses
      do_reset();
      nid = 0; pulses = 0; prev_g = 4'b0000;
      for (int i = 0; i < 49; i++) begin
         drive(1'b1, 4'b1111);
         if (prev_g == 4'b0000 && grant != 4'b0000 && nid < 5) begin
            ids[nid] = int'(grant_id);
            nid++;
         end
         if (slot_done === 1'b1) pulses++;
         prev_g = grant;
      end
      check("rr_grants", nid, 5);
      for (int i = 0; i < 5; i++) check($sformatf("rr_id%0d", i), ids[i], i % NREQ);
      check("rr_pulses", pulses, 4);

      // Pause at slot_count 5
      do_reset();
      repeat (6) drive(1'b1, 4'b0001);
      check("pause_at5", slot_count, 5);
      repeat (3) drive(1'b0, 4'b0001);
      check("pause_hold", {grant, slot_count}, {4'b0001, 4'd5});
      drive(1'b1, 4'b0001);
      check("pause_resume", slot_count, 6);
      repeat (3) drive(1'b1, 4'b0001);
      check("pause_last", {slot_count, slot_done}, {4'd9, 1'b0});
      drive(1'b1, 4'b0001);
      check("pause_expire", {grant, slot_done}, {4'b0000, 1'b1});

      // Early drop of requester 2 at slot_count 3
      do_reset();
      drive(1'b1, 4'b1100);
      check("drop_first", grant_id, 2);
      repeat (3) drive(1'b1, 4'b1100);
      check("drop_cnt3", slot_count, 3);
      drive(1'b1, 4'b1000);
      check("drop_release", {grant, slot_done}, {4'b0000, 1'b0});
      drive(1'b1, 4'b1000);
      drive(1'b1, 4'b1000);
      check("drop_next", {grant, grant_id}, {4'b1000, 2'd3});

      // Asynchronous reset mid-slot, observed before the next clock edge
      do_reset();
      repeat (8) drive(1'b1, 4'b1111);
      check("async_pre", slot_count, 7);
      #3;
      reset = 1'b0;
      #1;
      check("async_clear", {grant, grant_valid, slot_count}, 9'h000);
      model_reset();
      @(posedge clk);
      #1;
      model_compare();
      reset = 1'b1;
      drive(1'b1, 4'b1111);
      check("async_first", {grant, grant_id}, {4'b0001, 2'd0});

      // Randomized traffic against the model
      do_reset();
      rq = 4'b0000;
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 7) == 0) rq = 4'($urandom);
         en = ($urandom_range(0, 9) != 0);
         drive(en, rq);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
